vgac_param: RTL and testbench
=============================

VGAC_PARAM -- requirements
Module: vgac_param

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync width, back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync width, back porch in lines.
REQ-005 Parameter HS_POL / VS_POL, default 0 / 0, sync pulse level (0 = active-low).
REQ-006 Parameter RD_LAT, default 1, range 1..4, pixel-RAM read latency in clocks from address to d_in.
REQ-007 Parameter CW, default 4, bits per colour channel.
REQ-008 vga_clk  in  1  pixel clock; all logic on rising edge.
REQ-009 rst_n  in  1  reset, asynchronous and active-low.
REQ-010 d_in  in  3*CW  pixel data {r,g,b}, valid RD_LAT clocks after the address that requested it.
REQ-011 scale2x  in  1  2x pixel/line replication request.
REQ-012 row_addr  out  9  pixel RAM row address.
REQ-013 col_addr  out  10  pixel RAM column address.
REQ-014 r, g, b  out  CW each  colour outputs.
REQ-015 hs, vs  out  1 each  horizontal/vertical sync.
REQ-016 de  out  1  data enable, high on visible pixels.
REQ-017 frame_start  out  1  one-clock pulse at start of each frame.
REQ-018 frame_cnt  out  16  completed-frame counter.

Function
REQ-019 H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOT likewise; h_cnt counts 0..H_TOT-1 and wraps to 0; v_cnt increments when h_cnt = H_TOT-1 and wraps V_TOT-1 -> 0.
REQ-020 Region order per line/frame: sync, back porch, active, front porch; sync when h_cnt < H_SYNC (v_cnt < V_SYNC).
REQ-021 Active when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and same form vertically.
REQ-022 Offsets: hx = h_cnt-(H_SYNC+H_BP), vy = v_cnt-(V_SYNC+V_BP); col_addr = hx>>s, row_addr = vy>>s (truncated to port width), s = latched scale mode.
REQ-023 scale2x sampled only when h_cnt = 0 and v_cnt = 0; latched mode holds for the whole frame; mid-frame changes ignored.
REQ-024 row_addr/col_addr registered: valid 1 clock after counter state; outside active region they hold the computed (out-of-range) value, no RAM-side gating.
REQ-025 r/g/b registered from d_in: pixel for counter state T appears at T+RD_LAT+2; forced to 0 when the aligned de is low.
REQ-026 hs, vs, de, frame_start delayed through a RD_LAT+2 stage pipeline so all change on the same edge as the matching r/g/b.
REQ-027 hs = HS_POL during sync, ~HS_POL otherwise; vs likewise with VS_POL.
REQ-028 frame_start asserted for exactly one clock, aligned to counter state (0,0).
REQ-029 frame_cnt increments by 1 at h_cnt = H_TOT-1 and v_cnt = V_TOT-1, wraps 16'hFFFF -> 0.

Reset
REQ-030 While rst_n low: h_cnt, v_cnt, row_addr, col_addr, r, g, b, de, frame_start, frame_cnt = 0; hs = ~HS_POL, vs = ~VS_POL; all pipeline stages cleared to these values; scale mode = 0.
REQ-031 Reset asserted mid-frame clears immediately (asynchronous); on release counting restarts at (0,0), first frame_start pulse at RD_LAT+2 clocks after the first active edge.

Verification
REQ-032 Defaults, RD_LAT=1, scale2x=0, run 2 frames: hs low 96 clocks per 800; vs low 2 lines per 525; de high 640 clocks/line on 480 lines; frame_cnt = 2 after 2x420000 clocks.
REQ-033 d_in driven as function of previous-clock addresses (RAM model, RD_LAT=1..4): first visible pixel of each line equals RAM[vy][0]; r/g/b = 0 whenever de = 0.
REQ-034 scale2x=1 at frame start: col_addr sequence 0,0,1,1,...,319,319; row_addr repeats each value on 2 consecutive lines, max 239.
REQ-035 Toggle scale2x mid-frame: addressing unchanged until next (0,0), switches on the following frame.
REQ-036 rst_n pulsed low at h_cnt=300, v_cnt=200: outputs reach reset values without a clock edge; after release, frame_start pulses once, 3 clocks (RD_LAT=1) after release.
REQ-037 HS_POL=1, VS_POL=1, frame_cnt preset near wrap via long run or forced: hs/vs high during sync only; frame_cnt 16'hFFFF -> 0.

Source files
------------

// File: rtl/vgac_param_if.sv
// Pixel-RAM and display-side signals of the parameterised VGA timing controller.
// master = controller, slave = RAM/display/bench side.
interface vgac_param_if #(
  parameter int CW = 4
);
  logic [3*CW-1:0] d_in;
  logic            scale2x;
  logic [8:0]      row_addr;
  logic [9:0]      col_addr;
  logic [CW-1:0]   r, g, b;
  logic            hs, vs, de, frame_start;
  logic [15:0]     frame_cnt;

  modport master (
    input  d_in, scale2x,
    output row_addr, col_addr, r, g, b, hs, vs, de, frame_start, frame_cnt
  );
  modport slave (
    output d_in, scale2x,
    input  row_addr, col_addr, r, g, b, hs, vs, de, frame_start, frame_cnt
  );
endinterface

// File: rtl/vgac_param.sv
// Parameterised VGA timing generator with pixel-RAM addressing, optional 2x replication,
// and sync/enable outputs delayed to line up with the RAM read latency.
module vgac_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 1,
  parameter int CW       = 4
) (
  input logic          vga_clk,
  input logic          rst_n,
  vgac_param_if.master bus
);
  localparam int H_TOT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // one spare bit so H_TOT itself is representable in the region compares
  localparam int HW     = $clog2(H_TOT + 1);
  localparam int VW     = $clog2(V_TOT + 1);
  localparam int HOFF   = H_SYNC + H_BP;
  localparam int VOFF   = V_SYNC + V_BP;
  localparam int STAGES = RD_LAT + 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, fs: 1'b0};

  logic [HW-1:0] h_cnt, hx;
  logic [VW-1:0] v_cnt, vy;
  logic          h_last, v_last, frame_top;
  logic          h_sync, v_sync, h_act, v_act;
  logic          scale_q, scale_s;
  logic [8:0]    row_q;
  logic [9:0]    col_q;
  logic [15:0]   fcnt;
  logic [3*CW-1:0] rgb;
  ctl_t          ctl_now;
  ctl_t [STAGES:1] vld_pipe;

  assign h_last    = (h_cnt == HW'(H_TOT - 1));
  assign v_last    = (v_cnt == VW'(V_TOT - 1));
  assign frame_top = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Mode is taken live at (0,0) so the whole frame, including its first state, uses it.
  assign scale_s = frame_top ? bus.scale2x : scale_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) scale_q <= 1'b0;
    else        scale_q <= scale_s;
  end

  assign h_sync = h_cnt < HW'(H_SYNC);
  assign v_sync = v_cnt < VW'(V_SYNC);
  assign h_act  = (h_cnt >= HW'(HOFF)) && (h_cnt < HW'(HOFF + H_ACTIVE));
  assign v_act  = (v_cnt >= VW'(VOFF)) && (v_cnt < VW'(VOFF + V_ACTIVE));

  // Offsets wrap outside the active window; the RAM sees those values unchanged.
  assign hx = h_cnt - HW'(HOFF);
  assign vy = v_cnt - VW'(VOFF);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= 10'(hx >> scale_s);
      row_q <= 9'(vy >> scale_s);
    end
  end

  assign ctl_now = '{hs: h_sync ? HS_POL : ~HS_POL,
                     vs: v_sync ? VS_POL : ~VS_POL,
                     de: h_act & v_act,
                     fs: frame_top};

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= {STAGES{CTL_RST}};
    else        vld_pipe <= {vld_pipe[STAGES-1:1], ctl_now};
  end

  // Data for stage STAGES-1 arrives now; capture it so it leaves with the last stage.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)                      rgb <= '0;
    else if (vld_pipe[STAGES-1].de) rgb <= bus.d_in;
    else                            rgb <= '0;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)                fcnt <= '0;
    else if (h_last && v_last) fcnt <= fcnt + 16'd1;
  end

  assign bus.row_addr    = row_q;
  assign bus.col_addr    = col_q;
  assign bus.r           = rgb[3*CW-1:2*CW];
  assign bus.g           = rgb[2*CW-1:CW];
  assign bus.b           = rgb[CW-1:0];
  assign bus.hs          = vld_pipe[STAGES].hs;
  assign bus.vs          = vld_pipe[STAGES].vs;
  assign bus.de          = vld_pipe[STAGES].de;
  assign bus.frame_start = vld_pipe[STAGES].fs;
  assign bus.frame_cnt   = fcnt;
endmodule

// File: tb/tb_vgac_param.sv
// Bench for vgac_param: two small-timing instances (RD_LAT=1 active-low, RD_LAT=3 active-high)
// fed from RAM models, checked cycle by cycle against a queued reference plus scenario tasks.
module tb_vgac_param;
  localparam int HA = 16, HF = 3, HSY = 4, HB = 5;
  localparam int VA = 8,  VF = 2, VSY = 2, VB = 3;
  localparam int HT = HSY + HB + HA + HF;  // 28
  localparam int VT = VSY + VB + VA + VF;  // 15
  localparam int FT = HT * VT;             // 420
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scale = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vgac_param_if #(.CW(CW)) ba ();
  vgac_param_if #(.CW(CW)) bb ();

  vgac_param #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
               .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1), .CW(CW))
    ua (.vga_clk(clk), .rst_n(rst_n), .bus(ba.master));

  vgac_param #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
               .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(3), .CW(CW))
    ub (.vga_clk(clk), .rst_n(rst_n), .bus(bb.master));

  function automatic logic [11:0] ram(input logic [8:0] row, input logic [9:0] col);
    return 12'(row * 37 + col * 5 + 3) ^ 12'h5A5;
  endfunction

  // RAM models: data for the address seen on one clock appears RD_LAT clocks later.
  logic [11:0] rpa;
  logic [11:0] rpb [0:2];
  always @(posedge clk) begin
    rpa    <= ram(ba.row_addr, ba.col_addr);
    rpb[0] <= ram(bb.row_addr, bb.col_addr);
    rpb[1] <= rpb[0];
    rpb[2] <= rpb[1];
  end
  assign ba.d_in    = rpa;
  assign bb.d_in    = rpb[2];
  assign ba.scale2x = scale;
  assign bb.scale2x = scale;

  typedef struct packed {
    logic        hsy;
    logic        vsy;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   mh, mv, mf;
  logic ms;
  logic ea_act;
  int   ea_hx, ea_vy;
  logic [9:0] ea_col;
  logic [8:0] ea_row;

  // Reference timing model: one expected output pushed per counter state.
  always @(posedge clk or negedge rst_n) begin : model
    exp_t e;
    logic s;
    int   hx, vy;
    if (!rst_n) begin
      mh <= 0; mv <= 0; mf <= 0; ms <= 1'b0; ea_act <= 1'b0;
      ea_hx <= 0; ea_vy <= 0; ea_col <= '0; ea_row <= '0;
      qa.delete(); qb.delete();
    end else begin
      s     = (mh == 0 && mv == 0) ? scale : ms;
      hx    = mh - (HSY + HB);
      vy    = mv - (VSY + VB);
      e.hsy = (mh < HSY);
      e.vsy = (mv < VSY);
      e.de  = (hx >= 0) && (hx < HA) && (vy >= 0) && (vy < VA);
      e.fs  = (mh == 0) && (mv == 0);
      e.rgb = e.de ? ram(9'(vy >> s), 10'(hx >> s)) : 12'h000;
      qa.push_back(e);
      qb.push_back(e);
      ms     <= s;
      ea_act <= e.de;
      ea_hx  <= hx;
      ea_vy  <= vy;
      ea_col <= 10'(hx >> s);
      ea_row <= 9'(vy >> s);
      if (mh == HT - 1) begin
        mh <= 0;
        if (mv == VT - 1) begin mv <= 0; mf <= mf + 1; end
        else mv <= mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    logic [15:0] got, want;
    if (rst_n) begin
      if (qa.size() >= 3) begin
        e    = qa.pop_front();
        want = {~e.hsy, ~e.vsy, e.de, e.fs, e.rgb};
        got  = {ba.hs, ba.vs, ba.de, ba.frame_start, ba.r, ba.g, ba.b};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL sb_a_out t=%0t got %h want %h", $time, got, want);
        end
      end
      if (qb.size() >= 5) begin
        e    = qb.pop_front();
        want = {e.hsy, e.vsy, e.de, e.fs, e.rgb};
        got  = {bb.hs, bb.vs, bb.de, bb.frame_start, bb.r, bb.g, bb.b};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL sb_b_out t=%0t got %h want %h", $time, got, want);
        end
      end
      if (ea_act) begin
        checks++;
        if ({ba.row_addr, ba.col_addr} !== {ea_row, ea_col} ||
            {bb.row_addr, bb.col_addr} !== {ea_row, ea_col}) begin
          errors++;
          $display("FAIL sb_addr t=%0t got a=%h/%h b=%h/%h want %h/%h", $time,
                   ba.row_addr, ba.col_addr, bb.row_addr, bb.col_addr, ea_row, ea_col);
        end
      end
      checks++;
      if (ba.frame_cnt !== 16'(mf)) begin
        errors++;
        $display("FAIL sb_frame_cnt t=%0t got %0d want %0d", $time, ba.frame_cnt, mf);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ba.row_addr, ba.col_addr, ba.r, ba.g, ba.b, ba.de, ba.frame_start, ba.frame_cnt,
         ba.hs, ba.vs} !== {9'd0, 10'd0, 12'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_a got row=%h col=%h rgb=%h%h%h de=%b fs=%b fc=%h hs=%b vs=%b",
               ba.row_addr, ba.col_addr, ba.r, ba.g, ba.b, ba.de, ba.frame_start,
               ba.frame_cnt, ba.hs, ba.vs);
    end
    checks++;
    if ({bb.hs, bb.vs, bb.de, bb.frame_cnt} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_b got hs=%b vs=%b de=%b fc=%h want 0 0 0 0",
               bb.hs, bb.vs, bb.de, bb.frame_cnt);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_frames();
    int de_n = 0, hs_lo = 0, vs_lo = 0, hs_hi_b = 0, vs_hi_b = 0;
    for (int i = 1; i <= 2 * FT; i++) begin
      @(negedge clk);
      if (i > 10 && i <= 10 + FT) begin
        de_n    += int'(ba.de);
        hs_lo   += int'(!ba.hs);
        vs_lo   += int'(!ba.vs);
        hs_hi_b += int'(bb.hs);
        vs_hi_b += int'(bb.vs);
      end
    end
    checks++;
    if (de_n != HA * VA) begin errors++; $display("FAIL de_count got %0d want %0d", de_n, HA * VA); end
    checks++;
    if (hs_lo != HSY * VT) begin errors++; $display("FAIL hs_low got %0d want %0d", hs_lo, HSY * VT); end
    checks++;
    if (vs_lo != VSY * HT) begin errors++; $display("FAIL vs_low got %0d want %0d", vs_lo, VSY * HT); end
    checks++;
    if (hs_hi_b != HSY * VT || vs_hi_b != VSY * HT) begin
      errors++;
      $display("FAIL pol_b got hs_hi=%0d vs_hi=%0d want %0d %0d", hs_hi_b, vs_hi_b, HSY * VT, VSY * HT);
    end
    checks++;
    if (ba.frame_cnt !== 16'd2) begin errors++; $display("FAIL frame_cnt_2 got %0d want 2", ba.frame_cnt); end
  endtask

  task automatic wait_frame(input string name);
    int   prev = mf;
    logic ok = 1'b0;
    for (int i = 0; i < FT + 5 && !ok; i++) begin
      @(negedge clk);
      if (mf != prev) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout got no frame want frame end", name); end
  endtask

  task automatic test_scale2x();
    int n = 0, rmax = 0;
    scale = 1'b1;
    wait_frame("scale2x");
    for (int i = 0; i < FT - 2; i++) begin
      @(negedge clk);
      if (ea_act && ea_vy == 0) begin
        checks++;
        if (ba.col_addr !== 10'(n / 2)) begin
          errors++;
          $display("FAIL scale_col idx=%0d got %0d want %0d", n, ba.col_addr, n / 2);
        end
        n++;
      end
      if (ea_act && ea_hx == 0) begin
        checks++;
        if (ba.row_addr !== 9'(ea_vy / 2)) begin
          errors++;
          $display("FAIL scale_row line=%0d got %0d want %0d", ea_vy, ba.row_addr, ea_vy / 2);
        end
        if (int'(ba.row_addr) > rmax) rmax = int'(ba.row_addr);
      end
    end
    checks++;
    if (n != HA || rmax != VA / 2 - 1) begin
      errors++;
      $display("FAIL scale_span got cols=%0d rmax=%0d want %0d %0d", n, rmax, HA, VA / 2 - 1);
    end
  endtask

  task automatic test_scale_toggle();
    logic ok;
    wait_frame("toggle_a");
    repeat (200) @(negedge clk);
    scale = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < HT && !ok; i++) begin
      @(negedge clk);
      if (ea_act && ea_hx == 10) begin
        ok = 1'b1;
        checks++;
        if (ba.col_addr !== 10'd5) begin
          errors++;
          $display("FAIL toggle_hold got %0d want 5", ba.col_addr);
        end
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL toggle_hold_seen got none want hx=10"); end
    wait_frame("toggle_b");
    ok = 1'b0;
    for (int i = 0; i < FT && !ok; i++) begin
      @(negedge clk);
      if (ea_act && ea_hx == 10) begin
        ok = 1'b1;
        checks++;
        if (ba.col_addr !== 10'd10) begin
          errors++;
          $display("FAIL toggle_switch got %0d want 10", ba.col_addr);
        end
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL toggle_switch_seen got none want hx=10"); end
  endtask

  task automatic test_reset_mid();
    logic ok = 1'b0;
    int   first = 0, pulses = 0;
    for (int i = 0; i < FT + 5 && !ok; i++) begin
      @(negedge clk);
      if (mh == 10 && mv == 6) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_reach got none want (10,6)"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ba.row_addr, ba.col_addr, ba.r, ba.g, ba.b, ba.de, ba.frame_start, ba.frame_cnt,
         ba.hs, ba.vs} !== {9'd0, 10'd0, 12'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_a got row=%h col=%h fc=%h hs=%b vs=%b de=%b",
               ba.row_addr, ba.col_addr, ba.frame_cnt, ba.hs, ba.vs, ba.de);
    end
    checks++;
    if ({bb.hs, bb.vs, bb.row_addr, bb.col_addr} !== {1'b0, 1'b0, 9'd0, 10'd0}) begin
      errors++;
      $display("FAIL rst_mid_b got hs=%b vs=%b row=%h col=%h want 0", bb.hs, bb.vs, bb.row_addr, bb.col_addr);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ba.frame_start) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first != 3 || pulses != 1) begin
      errors++;
      $display("FAIL rst_mid_fs got first=%0d pulses=%0d want 3 1", first, pulses);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] prev = 16'hFFFE;
    int          n_chg = 0;
    @(posedge clk);
    #2 force ub.fcnt = 16'hFFFE;
    #1 release ub.fcnt;
    for (int i = 0; i < 2 * FT + 10 && n_chg < 2; i++) begin
      @(negedge clk);
      if (bb.frame_cnt !== prev) begin
        n_chg++;
        checks++;
        if (bb.frame_cnt !== ((n_chg == 1) ? 16'hFFFF : 16'h0000)) begin
          errors++;
          $display("FAIL wrap_step%0d got %h want %h", n_chg, bb.frame_cnt,
                   (n_chg == 1) ? 16'hFFFF : 16'h0000);
        end
        prev = bb.frame_cnt;
      end
    end
    checks++;
    if (n_chg != 2) begin errors++; $display("FAIL wrap_timeout got %0d steps want 2", n_chg); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_scale2x();
    test_scale_toggle();
    test_reset_mid();
    test_wrap();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
